// File: rtl/dt_pkg.sv
// dt_pkg: shared types for the distance-transform result RAM arbiter.
// RAM geometry, arbiter state encoding and the requester bundle.
package dt_pkg;

  localparam int AW = 14;
  localparam int DW = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OWN0,
    ST_OWN1
  } arb_state_t;

  typedef struct packed {
    logic          valid;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          lock;
  } dt_req_t;

endpackage

// File: rtl/dt_arb_pick.sv
// dt_arb_pick: two-way winner select for the result RAM arbiter.
// DT_RES_ARB_RR_EN selects round robin, otherwise port 0 has priority.
module dt_arb_pick (
  input  logic v0,
  input  logic v1,
  input  logic last,
  output logic win
);

`ifdef DT_RES_ARB_RR_EN
  assign win = (v0 & v1) ? ~last : ~v0;
`else
  logic unused_last;
  assign unused_last = last;
  assign win = ~v0;
`endif

endmodule

// File: rtl/dt_res_arbiter.sv
// dt_res_arbiter: shares the result RAM between the DT engine (port 0)
// and host engine (port 1); DT_RES_ARB_RR_EN enables round robin.
module dt_res_arbiter #(
  parameter int AW        = dt_pkg::AW,
  parameter int DW        = dt_pkg::DW,
  parameter int MAX_BURST = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  input  logic          req0_wr,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  input  logic          req0_lock,
  input  logic          req1_valid,
  input  logic          req1_wr,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  input  logic          req1_lock,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          res_rd,
  output logic          res_wr,
  output logic [AW-1:0] res_addr,
  output logic [DW-1:0] res_do,
  input  logic [DW-1:0] res_di
);
  import dt_pkg::*;

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_BURST);

  dt_req_t       r0;
  dt_req_t       r1;
  arb_state_t    state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          last;
  logic          win;
  logic          acc0;
  logic          acc1;
  logic          own_v;
  logic          own_lk;
  logic          oth_v;
  logic          rel;
  logic          res_tag;
  logic          rd_q;
  logic          tag_q;

  assign r0 = {req0_valid, req0_wr, req0_addr, req0_wdata, req0_lock};
  assign r1 = {req1_valid, req1_wr, req1_addr, req1_wdata, req1_lock};

  assign gnt0 = (state == ST_OWN0);
  assign gnt1 = (state == ST_OWN1);
  assign acc0 = r0.valid & gnt0;
  assign acc1 = r1.valid & gnt1;

  assign own_v  = gnt1 ? r1.valid : r0.valid;
  assign own_lk = gnt1 ? r1.lock  : r0.lock;
  assign oth_v  = gnt1 ? r0.valid : r1.valid;

  // Count includes the beat taken at this edge, so a tenure never exceeds MAX_BURST.
  assign cnt_nxt = ((acc0 | acc1) && cnt != CMAX) ? cnt + CW'(1) : cnt;
  assign rel = !own_lk && (!own_v || (cnt_nxt == CMAX && oth_v));

  dt_arb_pick u_pick (
    .v0   (r0.valid),
    .v1   (r1.valid),
    .last (last),
    .win  (win)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      last  <= 1'b1;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (r0.valid | r1.valid) begin
            state <= win ? ST_OWN1 : ST_OWN0;
            last  <= win;
            cnt   <= '0;
          end
        end
        ST_OWN0, ST_OWN1: begin
          cnt <= cnt_nxt;
          if (rel) begin
            cnt <= '0;
            if (oth_v) begin
              state <= gnt0 ? ST_OWN1 : ST_OWN0;
              last  <= gnt0;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Synchronous RAM: data for a read issued in one cycle is captured two edges later.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_rd   <= 1'b0;
      res_wr   <= 1'b0;
      res_addr <= '0;
      res_do   <= '0;
      res_tag  <= 1'b0;
      rd_q     <= 1'b0;
      tag_q    <= 1'b0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      rdata    <= '0;
    end else begin
      res_rd <= 1'b0;
      res_wr <= 1'b0;
      unique case (1'b1)
        acc0: begin
          res_rd   <= !r0.wr;
          res_wr   <= r0.wr;
          res_addr <= r0.addr;
          res_do   <= r0.wdata;
          res_tag  <= 1'b0;
        end
        acc1: begin
          res_rd   <= !r1.wr;
          res_wr   <= r1.wr;
          res_addr <= r1.addr;
          res_do   <= r1.wdata;
          res_tag  <= 1'b1;
        end
        default: ;
      endcase
      rd_q    <= res_rd;
      tag_q   <= res_tag;
      rvalid0 <= rd_q & ~tag_q;
      rvalid1 <= rd_q & tag_q;
      if (rd_q) rdata <= res_di;
    end
  end

endmodule

// File: tb/tb_dt_res_arbiter.sv
// tb_dt_res_arbiter: directed and randomized checks of the result RAM
// arbiter against a transaction-level model; honours DT_RES_ARB_RR_EN.
module tb_dt_res_arbiter;

  localparam int AW = 14;
  localparam int DW = 8;
  localparam int MB = 16;
  localparam int N  = 1 << AW;

  typedef struct {
    int            due;
    int            port;
    logic [DW-1:0] d;
  } rd_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          vld [2];
  logic          wr  [2];
  logic          lck [2];
  logic [AW-1:0] adr [2];
  logic [DW-1:0] wd  [2];
  logic          gnt0, gnt1, rvalid0, rvalid1, res_rd, res_wr;
  logic [DW-1:0] rdata, res_do, res_di;
  logic [AW-1:0] res_addr;
  logic [35:0]   obs;

  bit   [DW-1:0] mem [N];
  logic [DW-1:0] ref_mem [N];
  rd_t           rq [$];
  int            m_own, m_beats, m_last, cyc;
  logic          m_rd, m_wr, m_rv0, m_rv1;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_do, m_rdata;
  int            n_chk = 0;
  int            n_pass = 0;

  always #5 clk = ~clk;

  dt_res_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (vld[0]),
    .req0_wr    (wr[0]),
    .req0_addr  (adr[0]),
    .req0_wdata (wd[0]),
    .req0_lock  (lck[0]),
    .req1_valid (vld[1]),
    .req1_wr    (wr[1]),
    .req1_addr  (adr[1]),
    .req1_wdata (wd[1]),
    .req1_lock  (lck[1]),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .rvalid0    (rvalid0),
    .rvalid1    (rvalid1),
    .rdata      (rdata),
    .res_rd     (res_rd),
    .res_wr     (res_wr),
    .res_addr   (res_addr),
    .res_do     (res_do),
    .res_di     (res_di)
  );

  assign obs = {gnt0, gnt1, res_rd, res_wr, res_addr, res_do,
                rvalid0, rvalid1, rdata};

  // Unwritten RAM words read back as pad(addr).
  function automatic logic [DW-1:0] pad(logic [AW-1:0] a);
    return a[7:0] + 8'h84;
  endfunction

  always @(posedge clk) begin
    if (res_wr) mem[res_addr] <= res_do ^ pad(res_addr);
    if (res_rd) res_di <= mem[res_addr] ^ pad(res_addr);
  end

  function automatic logic [35:0] mexp();
    return {m_own == 0, m_own == 1, m_rd, m_wr, m_addr, m_do,
            m_rv0, m_rv1, m_rdata};
  endfunction

  function automatic void model_clear();
    m_own = -1; m_beats = 0; m_last = 1;
    m_rd = 0; m_wr = 0; m_addr = '0; m_do = '0;
    m_rv0 = 0; m_rv1 = 0; m_rdata = '0;
    rq.delete();
  endfunction

  function automatic void enter(int w);
    m_own = w; m_beats = 0; m_last = w;
  endfunction

  function automatic int pick(bit v0, bit v1);
    if (v0 && v1) begin
`ifdef DT_RES_ARB_RR_EN
      return 1 - m_last;
`else
      return 0;
`endif
    end
    return v0 ? 0 : 1;
  endfunction

  // One rising edge of the reference: accept, command, return, arbitrate.
  function automatic void model_edge();
    int  a, o;
    rd_t r;
    cyc++;
    if (reset) begin
      model_clear();
      return;
    end
    a = (m_own >= 0 && vld[m_own]) ? m_own : -1;
    m_rv0 = 0; m_rv1 = 0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      r = rq.pop_front();
      if (r.port == 0) m_rv0 = 1; else m_rv1 = 1;
      m_rdata = r.d;
    end
    if (a >= 0) begin
      m_rd = !wr[a]; m_wr = wr[a]; m_addr = adr[a]; m_do = wd[a];
      if (wr[a]) ref_mem[adr[a]] = wd[a];
      else rq.push_back('{cyc + 2, a, ref_mem[adr[a]]});
    end else begin
      m_rd = 0; m_wr = 0;
    end
    if (m_own < 0) begin
      if (vld[0] || vld[1]) enter(pick(vld[0], vld[1]));
    end else begin
      o = m_own;
      if (a >= 0 && m_beats < MB) m_beats++;
      if (!lck[o] && (!vld[o] || (m_beats == MB && vld[1-o]))) begin
        if (vld[1-o]) enter(1 - o);
        else m_own = -1;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_req(int p, bit v, bit w, logic [AW-1:0] a,
                         logic [DW-1:0] d, bit l);
    vld[p] = v; wr[p] = w; adr[p] = a; wd[p] = d; lck[p] = l;
  endtask

  task automatic idle_all();
    set_req(0, 0, 0, '0, '0, 0);
    set_req(1, 0, 0, '0, '0, 0);
    repeat (4) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_chk++;
    if (obs !== 36'd0) $display("FAIL reset_outputs: got %h want 0", obs);
    else n_pass++;
    reset = 1'b0;
    tick();
    n_chk++;
    if (obs !== mexp()) $display("FAIL reset_idle: got %h want %h", obs, mexp());
    else n_pass++;
  endtask

  task automatic test_contention();
    int exp_w;
    set_req(0, 1, 0, 14'h0010, '0, 0);
    set_req(1, 1, 0, 14'h0020, '0, 0);
    tick();
    n_chk++;
    if ({gnt0, gnt1} !== 2'b10)
      $display("FAIL contention_first: gnt=%b want 10", {gnt0, gnt1});
    else n_pass++;
    repeat (2) tick();
    vld[0] = 1'b0;
    tick();
    n_chk++;
    if ({gnt0, gnt1} !== 2'b01)
      $display("FAIL contention_handover: gnt=%b want 01", {gnt0, gnt1});
    else n_pass++;
    n_chk++;
    if (obs !== mexp()) $display("FAIL contention_model: got %h want %h", obs, mexp());
    else n_pass++;
    vld[1] = 1'b0;
    idle_all();
    // Port 0 served alone, so round robin now favours port 1.
    set_req(0, 1, 0, 14'h0011, '0, 0);
    tick();
    tick();
    vld[0] = 1'b0;
    tick();
    set_req(0, 1, 0, 14'h0012, '0, 0);
    set_req(1, 1, 0, 14'h0022, '0, 0);
    tick();
`ifdef DT_RES_ARB_RR_EN
    exp_w = 1;
`else
    exp_w = 0;
`endif
    n_chk++;
    if ({gnt0, gnt1} !== (exp_w == 1 ? 2'b01 : 2'b10))
      $display("FAIL contention_policy: gnt=%b want port %0d", {gnt0, gnt1}, exp_w);
    else n_pass++;
    idle_all();
  endtask

  task automatic test_single_read();
    set_req(0, 1, 0, 14'h0081, '0, 0);
    tick();
    n_chk++;
    if (gnt0 !== 1'b1) $display("FAIL read_grant: gnt0=%b want 1", gnt0);
    else n_pass++;
    tick();
    n_chk++;
    if ({res_rd, res_wr, res_addr} !== {1'b1, 1'b0, 14'h0081})
      $display("FAIL read_cmd: rd=%b wr=%b addr=%h want 1 0 0081",
               res_rd, res_wr, res_addr);
    else n_pass++;
    vld[0] = 1'b0;
    tick();
    n_chk++;
    if (rvalid0 !== 1'b0) $display("FAIL read_early: rvalid0=%b want 0", rvalid0);
    else n_pass++;
    tick();
    n_chk++;
    if ({rvalid0, rvalid1, rdata} !== {2'b10, 8'h05})
      $display("FAIL read_data: rv=%b%b rdata=%h want 10 05", rvalid0, rvalid1, rdata);
    else n_pass++;
    n_chk++;
    if (obs !== mexp()) $display("FAIL read_model: got %h want %h", obs, mexp());
    else n_pass++;
    idle_all();
  endtask

  task automatic test_burst();
    int done0 = 0, done1 = 0, nwr = 0, lost_at = -1, p1_before = -1;
    bit a0, a1, had;
    set_req(0, 1, 1, 14'h1000, 8'h5A, 0);
    tick();
    set_req(1, 1, 0, 14'h2000, '0, 0);
    for (int c = 0; c < 400 && done0 < 40; c++) begin
      a0 = vld[0] & gnt0;
      a1 = vld[1] & gnt1;
      had = gnt0;
      tick();
      n_chk++;
      if (obs !== mexp()) $display("FAIL burst_model: got %h want %h", obs, mexp());
      else n_pass++;
      if (res_wr && res_addr[13:12] == 2'b01) nwr++;
      if (a0) begin
        done0++;
        if (done0 < 40) begin
          adr[0] = 14'h1000 + 14'(done0);
          wd[0] = 8'h5A ^ 8'(done0);
        end else vld[0] = 1'b0;
      end
      if (a1) begin
        done1++;
        adr[1] = adr[1] + 14'd1;
        if (done1 == 3) vld[1] = 1'b0;
      end
      if (had && !gnt0 && lost_at < 0) lost_at = done0;
      if (!had && gnt0 && lost_at >= 0 && p1_before < 0) p1_before = done1;
    end
    n_chk++;
    if (lost_at != MB) $display("FAIL burst_release: lost after %0d beats want %0d", lost_at, MB);
    else n_pass++;
    n_chk++;
    if (p1_before < 1) $display("FAIL burst_port1_served: %0d beats want >=1", p1_before);
    else n_pass++;
    n_chk++;
    if (done0 != 40) $display("FAIL burst_complete: %0d beats want 40", done0);
    else n_pass++;
    n_chk++;
    if (nwr != 40) $display("FAIL burst_writes: %0d writes want 40", nwr);
    else n_pass++;
    idle_all();
  endtask

  task automatic test_lock();
    set_req(1, 1, 0, 14'h0030, '0, 1);
    tick();
    tick();
    vld[1] = 1'b0;
    set_req(0, 1, 0, 14'h0040, '0, 0);
    for (int c = 0; c < 10; c++) begin
      tick();
      n_chk++;
      if ({gnt0, gnt1, res_rd, res_wr} !== 4'b0100)
        $display("FAIL lock_hold: cycle %0d gnt=%b%b rd=%b wr=%b want 01 0 0",
                 c, gnt0, gnt1, res_rd, res_wr);
      else n_pass++;
    end
    lck[1] = 1'b0;
    tick();
    n_chk++;
    if ({gnt0, gnt1} !== 2'b10)
      $display("FAIL lock_release: gnt=%b want 10", {gnt0, gnt1});
    else n_pass++;
    idle_all();
  endtask

  task automatic test_pressure();
    int run = 0, last_p = -1, p;
    bit a0, a1;
    set_req(0, 1, 0, 14'h0000, '0, 0);
    set_req(1, 1, 0, 14'h0100, '0, 0);
    for (int c = 0; c < 120; c++) begin
      a0 = vld[0] & gnt0;
      a1 = vld[1] & gnt1;
      tick();
      n_chk++;
      if (obs !== mexp()) $display("FAIL pressure_model: got %h want %h", obs, mexp());
      else n_pass++;
      if (a0 | a1) begin
        p = a1 ? 1 : 0;
        if (p == last_p) run++;
        else begin
          if (last_p >= 0) begin
            n_chk++;
            if (run != MB)
              $display("FAIL pressure_tenure: port %0d ran %0d beats want %0d", last_p, run, MB);
            else n_pass++;
          end
          last_p = p;
          run = 1;
        end
        adr[p] = AW'($urandom_range(0, 255));
      end
    end
    idle_all();
  endtask

  task automatic test_reset_mid();
    set_req(0, 1, 0, 14'h0081, '0, 0);
    tick();
    tick();
    reset = 1'b1;
    vld[0] = 1'b0;
    tick();
    n_chk++;
    if (obs !== 36'd0) $display("FAIL midreset_outputs: got %h want 0", obs);
    else n_pass++;
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_chk++;
      if ({rvalid0, rvalid1} !== 2'b00 || obs !== mexp())
        $display("FAIL midreset_quiet: got %h want %h", obs, mexp());
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 2; p++) begin
        vld[p] = ($urandom_range(0, 3) != 0);
        wr[p]  = 1'($urandom_range(0, 1));
        adr[p] = AW'($urandom_range(0, 15));
        wd[p]  = DW'($urandom);
        lck[p] = ($urandom_range(0, 7) == 0);
      end
      tick();
      n_chk++;
      if (obs !== mexp()) $display("FAIL random_model: cycle %0d got %h want %h", c, obs, mexp());
      else n_pass++;
    end
    idle_all();
  endtask

  initial begin
    for (int i = 0; i < 2; i++) set_req(i, 0, 0, '0, '0, 0);
    for (int i = 0; i < N; i++) ref_mem[i] = pad(AW'(i));
    cyc = 0;
    model_clear();
    test_reset();
    test_contention();
    test_single_read();
    test_burst();
    test_lock();
    test_pressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
